// File: rtl/motor_drive.sv
// PWM motor driver: ramps duty up to a cruise level, holds it for a fixed
// number of timebase ticks, then ramps back down and pulses done.
module motor_drive #(
  parameter int PWM_PERIOD  = 100,
  parameter int MAX_DUTY    = 80,
  parameter int RAMP_STEP   = 10,
  parameter int RUN_SECONDS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_forward,
  input  logic       oneHz_enable,
  output logic       pwm_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] state,
  output logic [7:0] o_dbg_duty,
  output logic [7:0] o_dbg_seconds
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RUN       = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(PWM_PERIOD - 1);
  localparam logic [8:0] LP_MAX  = 9'(MAX_DUTY);
  localparam logic [8:0] LP_STEP = 9'(RAMP_STEP);
  localparam logic [7:0] LP_SECS = 8'(RUN_SECONDS);

  state_t     r_state;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_duty;
  logic [7:0] r_seconds;
  logic       r_armed;
  logic       r_pwm;
  logic       r_busy;
  logic       r_done;

  logic       w_frame_end;
  logic [8:0] w_up_sum;
  logic [7:0] w_up_duty;
  logic [7:0] w_down_duty;
  logic [7:0] w_sec_inc;

  assign w_frame_end = (r_frame_cnt == LP_LAST);
  // Nine-bit sum so duty+step saturates at the cruise level instead of wrapping.
  assign w_up_sum    = {1'b0, r_duty} + LP_STEP;
  assign w_up_duty   = (w_up_sum >= LP_MAX) ? LP_MAX[7:0] : w_up_sum[7:0];
  assign w_down_duty = ({1'b0, r_duty} > LP_STEP) ? (r_duty - LP_STEP[7:0]) : 8'd0;
  assign w_sec_inc   = r_seconds + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (r_frame_cnt < r_duty);
    end
  end

  // Duty only moves on frame-end edges, so every frame carries one duty value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_duty    <= '0;
      r_seconds <= '0;
      r_armed   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!enable_forward) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (enable_forward && r_armed) begin
            r_state <= S_RAMP_UP;
            r_busy  <= 1'b1;
            r_armed <= 1'b0;
          end
        end
        S_RAMP_UP: begin
          if (!enable_forward) begin
            r_state <= S_RAMP_DOWN;
          end else if (w_frame_end) begin
            r_duty <= w_up_duty;
            if (w_up_duty == LP_MAX[7:0]) begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!enable_forward) begin
            r_state   <= S_RAMP_DOWN;
            r_seconds <= '0;
          end else if (oneHz_enable) begin
            if (w_sec_inc == LP_SECS) begin
              r_state   <= S_RAMP_DOWN;
              r_seconds <= '0;
            end else begin
              r_seconds <= w_sec_inc;
            end
          end
        end
        S_RAMP_DOWN: begin
          if (w_frame_end) begin
            r_duty <= w_down_duty;
            if (w_down_duty == 8'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out       = r_pwm;
  assign busy          = r_busy;
  assign done          = r_done;
  assign state         = r_state;
  assign o_dbg_duty    = r_duty;
  assign o_dbg_seconds = r_seconds;

endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive: a nominal and an edge-parameter instance share one
// stimulus stream; an event-timeline model predicts every output change.
module tb_motor_drive;

  localparam int P      = 10;
  localparam int MAX_M  = 8;
  localparam int STEP_M = 3;
  localparam int MAX_E  = 10;
  localparam int STEP_E = 10;
  localparam int RUN_S  = 2;
  localparam int TICK_P = 100;
  localparam int W      = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable_forward = 1'b0;
  logic oneHz_enable = 1'b0;

  logic       m_pwm, m_busy, m_done;
  logic [1:0] m_state;
  logic [7:0] m_duty, m_sec;
  logic       e_pwm, e_busy, e_done;
  logic [1:0] e_state;
  logic [7:0] e_duty, e_sec;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q_e[$];
  logic [19:0]  prev[2];
  int           cur_duty[2];
  int           win_duty[2];
  int           win_cnt[2];
  bit           win_valid[2];

  motor_drive #(.PWM_PERIOD(P), .MAX_DUTY(MAX_M), .RAMP_STEP(STEP_M), .RUN_SECONDS(RUN_S)) u_main (
    .clk(clk), .reset(reset), .enable_forward(enable_forward), .oneHz_enable(oneHz_enable),
    .pwm_out(m_pwm), .busy(m_busy), .done(m_done), .state(m_state),
    .o_dbg_duty(m_duty), .o_dbg_seconds(m_sec)
  );

  motor_drive #(.PWM_PERIOD(P), .MAX_DUTY(MAX_E), .RAMP_STEP(STEP_E), .RUN_SECONDS(RUN_S)) u_edge (
    .clk(clk), .reset(reset), .enable_forward(enable_forward), .oneHz_enable(oneHz_enable),
    .pwm_out(e_pwm), .busy(e_busy), .done(e_done), .state(e_state),
    .o_dbg_duty(e_duty), .o_dbg_seconds(e_sec)
  );

  // Clock / reset-relative edge counter: cyc == n after the n-th edge since release.
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [W-1:0] pack_ev(input int c, input int st, input int dn, input int du, input int sc);
    pack_ev = {20'(c), 2'(st), (st != 0), 1'(dn), 8'(du), 8'(sc)};
  endfunction

  function automatic string fmt_ev(input logic [W-1:0] e);
    fmt_ev = $sformatf("cyc=%0d st=%0d busy=%0d done=%0d duty=%0d sec=%0d",
                       e[39:20], e[19:18], e[17], e[16], e[15:8], e[7:0]);
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input int inst, input int c, input int st, input int dn, input int du, input int sc);
    if (inst == 0) exp_q.push_back(pack_ev(c, st, dn, du, sc));
    else           exp_q_e.push_back(pack_ev(c, st, dn, du, sc));
  endtask

  // Timeline model: motion starts at edge s, enable drops at edge d (0 = never),
  // ticks at edges n with (n+ofs)%TICK_P==0, frame ends at multiples of P.
  task automatic plan(input int inst, input int mx, input int st, input int s,
                      input int d, input int ofs, output int fin);
    int f, duty, t, secs, x;
    push(inst, s, 1, 0, 0, 0);
    duty = 0;
    x = 0;
    f = (s / P + 1) * P;
    while (1'b1) begin
      if (d != 0 && d <= f) begin
        x = d;
        push(inst, d, 3, 0, duty, 0);
        break;
      end
      duty = (duty + st > mx) ? mx : duty + st;
      if (duty == mx) begin
        push(inst, f, 2, 0, duty, 0);
        break;
      end
      push(inst, f, 1, 0, duty, 0);
      f += P;
    end
    if (x == 0) begin
      t = f;
      secs = 0;
      while (1'b1) begin
        t = ((t + ofs) / TICK_P + 1) * TICK_P - ofs;
        if (d != 0 && d <= t) begin
          x = d;
          push(inst, d, 3, 0, mx, 0);
          break;
        end
        secs++;
        if (secs == RUN_S) begin
          x = t;
          push(inst, t, 3, 0, mx, 0);
          break;
        end
        push(inst, t, 2, 0, mx, secs);
      end
    end
    f = (x / P + 1) * P;
    while (1'b1) begin
      duty = (duty > st) ? duty - st : 0;
      if (duty == 0) begin
        push(inst, f, 0, 1, 0, 0);
        push(inst, f + 1, 0, 0, 0, 0);
        fin = f + 1;
        break;
      end
      push(inst, f, 3, 0, duty, 0);
      f += P;
    end
  endtask

  // Driver: at each falling edge, set the inputs sampled by the next rising edge.
  task automatic drive_until(input int last, input int s, input int d, input int ofs);
    while (1'b1) begin
      @(negedge clk);
      if (cyc >= last) break;
      enable_forward = (cyc + 1 >= s) && (d == 0 || cyc + 1 < d);
      oneHz_enable   = ((cyc + 1 + ofs) % TICK_P) == 0;
    end
  endtask

  // kind: 0 held, 1 drop in first ramp-up frame, 2 drop on a RUN tick, 3 random drop
  task automatic motion(input int kind, input int hold, input int s_force);
    int s, d, ofs, f1, fnu, fin0, fin1, last;
    s   = (s_force != 0) ? s_force : cyc + 2 + $urandom_range(0, 12);
    ofs = $urandom_range(0, TICK_P - 1);
    f1  = (s / P + 1) * P;
    fnu = f1 + ((MAX_M + STEP_M - 1) / STEP_M - 1) * P;
    case (kind)
      1:       d = f1 + $urandom_range(1, P - 1);
      2:       d = ((fnu + ofs) / TICK_P + 1) * TICK_P - ofs;
      3:       d = s + $urandom_range(1, 150);
      default: d = 0;
    endcase
    plan(0, MAX_M, STEP_M, s, d, ofs, fin0);
    plan(1, MAX_E, STEP_E, s, d, ofs, fin1);
    last = (fin0 > fin1) ? fin0 : fin1;
    if (d > last) last = d;
    last += hold;
    drive_until(last, s, d, ofs);
    enable_forward = 1'b0;
    oneHz_enable   = 1'b0;
    check_int("drain_u0", exp_q.size(), 0);
    check_int("drain_u1", exp_q_e.size(), 0);
  endtask

  task automatic reset_during_run();
    int s, ofs, fnu, r, fin0, fin1;
    s   = cyc + 2 + $urandom_range(0, 8);
    ofs = $urandom_range(0, TICK_P - 1);
    fnu = (s / P + 1) * P + ((MAX_M + STEP_M - 1) / STEP_M - 1) * P;
    r   = fnu + $urandom_range(1, 8);
    plan(0, MAX_M, STEP_M, s, 0, ofs, fin0);
    plan(1, MAX_E, STEP_E, s, 0, ofs, fin1);
    drive_until(r, s, 0, ofs);
    oneHz_enable = 1'b0;
    check_int("pre_reset_state_u0", int'(m_state), 2);
    #2 reset = 1'b0;
    #1;
    check_int("async_u0", int'({m_pwm, m_busy, m_done, m_state, m_duty, m_sec}), 0);
    check_int("async_u1", int'({e_pwm, e_busy, e_done, e_state, e_duty, e_sec}), 0);
    exp_q.delete();
    exp_q_e.delete();
    repeat (3) begin
      @(negedge clk);
      check_int("rst_hold_u0", int'({m_pwm, m_busy, m_done, m_state}), 0);
      check_int("rst_hold_u1", int'({e_pwm, e_busy, e_done, e_state}), 0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic observe(input int inst, input logic [1:0] st, input logic bz, input logic dn,
                         input logic [7:0] du, input logic [7:0] sc, input logic pw);
    logic [19:0]  cur;
    logic [W-1:0] got;
    logic [W-1:0] exp_e;
    bit           have;
    cur = {st, bz, dn, du, sc};
    if (cur != prev[inst]) begin
      got   = {20'(cyc), cur};
      have  = 1'b0;
      exp_e = '0;
      checks++;
      if (inst == 0 && exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        have  = 1'b1;
      end
      if (inst == 1 && exp_q_e.size() > 0) begin
        exp_e = exp_q_e.pop_front();
        have  = 1'b1;
      end
      if (!have) begin
        errors++;
        $display("FAIL event_u%0d: got %s but no change expected", inst, fmt_ev(got));
      end else begin
        cur_duty[inst] = int'(exp_e[15:8]);
        if (got != exp_e) begin
          errors++;
          $display("FAIL event_u%0d: got %s expected %s", inst, fmt_ev(got), fmt_ev(exp_e));
        end
      end
      prev[inst] = cur;
    end
    if (cyc % P == 1) begin
      win_duty[inst]  = cur_duty[inst];
      win_cnt[inst]   = 0;
      win_valid[inst] = 1'b1;
    end
    if (win_valid[inst] && pw) win_cnt[inst]++;
    if (cyc % P == 0 && win_valid[inst]) begin
      check_int($sformatf("pwm_high_u%0d", inst), win_cnt[inst], win_duty[inst]);
      win_valid[inst] = 1'b0;
    end
  endtask

  // Monitor: compare whenever a DUT's visible state changes; count pwm high time per frame.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        prev[i]      = '0;
        cur_duty[i]  = 0;
        win_valid[i] = 1'b0;
      end
    end else begin
      observe(0, m_state, m_busy, m_done, m_duty, m_sec, m_pwm);
      observe(1, e_state, e_busy, e_done, e_duty, e_sec, e_pwm);
    end
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_int("reset_u0", int'({m_pwm, m_busy, m_done, m_state, m_duty, m_sec}), 0);
    check_int("reset_u1", int'({e_pwm, e_busy, e_done, e_state, e_duty, e_sec}), 0);
    #2 reset = 1'b1;
    motion(0, 40, 0);
    motion(1, 5, 0);
    motion(2, 5, 0);
    for (int i = 0; i < 12; i++) begin
      motion(int'($urandom_range(0, 3)), int'($urandom_range(2, 20)), 0);
    end
    reset_during_run();
    motion(0, 30, 1);
    motion(3, 5, 0);
    motion(2, 5, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
